// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding and block/round constants.
// Used by the round controller, the key schedule and the step units.
package aes_pkg;

   localparam int unsigned NUM_ROUNDS_128 = 10;
   localparam int unsigned BLOCK_W        = 128;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT_ARK,
      ST_SUB,
      ST_SHIFT,
      ST_MIX,
      ST_ARK,
      ST_DONE
   } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer: owns the cipher state register and steps it
// through the initial AddRoundKey, the full rounds and the final round.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_128,
   parameter int unsigned RW         = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [BLOCK_W-1:0] data_in,
   output logic               busy,
   output logic               done,
   output logic [BLOCK_W-1:0] data_out,
   output logic [BLOCK_W-1:0] cur_state,
   output logic [RW-1:0]      round_num,
   output logic               sbox_enable,
   output logic               srows_enable,
   output logic               mcols_enable,
   output logic               ark_enable,
   input  logic [BLOCK_W-1:0] sbox_out,
   input  logic [BLOCK_W-1:0] srows_out,
   input  logic [BLOCK_W-1:0] mcols_out,
   input  logic [BLOCK_W-1:0] ark_out,
   input  logic               sbox_done
);

   localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);

   ctrl_state_t        state, state_nxt;
   logic [BLOCK_W-1:0] cur_state_nxt;
   logic [BLOCK_W-1:0] data_out_nxt;
   logic [RW-1:0]      round_nxt;

   always_comb begin
      state_nxt     = state;
      cur_state_nxt = cur_state;
      data_out_nxt  = data_out;
      round_nxt     = round_num;
      case (state)
         ST_IDLE: begin
            if (start) begin
               cur_state_nxt = data_in;
               round_nxt     = '0;
               state_nxt     = ST_INIT_ARK;
            end
         end
         ST_INIT_ARK: begin
            cur_state_nxt = ark_out;
            round_nxt     = RW'(1);
            state_nxt     = ST_SUB;
         end
         ST_SUB: begin
            if (sbox_done) begin
               cur_state_nxt = sbox_out;
               state_nxt     = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            cur_state_nxt = srows_out;
            state_nxt     = (round_num < LAST_ROUND) ? ST_MIX : ST_ARK;
         end
         ST_MIX: begin
            cur_state_nxt = mcols_out;
            state_nxt     = ST_ARK;
         end
         ST_ARK: begin
            cur_state_nxt = ark_out;
            if (round_num == LAST_ROUND) begin
               data_out_nxt = ark_out;
               state_nxt    = ST_DONE;
            end else begin
               round_nxt = round_num + RW'(1);
               state_nxt = ST_SUB;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      // Abort freezes the datapath registers and only retargets the state.
      if (abort) begin
         state_nxt     = ST_IDLE;
         cur_state_nxt = cur_state;
         data_out_nxt  = data_out;
         round_nxt     = round_num;
      end
   end

   // Moore outputs are decoded from the next state so they are registered
   // alongside the state and line up with it cycle for cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cur_state    <= '0;
         data_out     <= '0;
         round_num    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sbox_enable  <= 1'b0;
         srows_enable <= 1'b0;
         mcols_enable <= 1'b0;
         ark_enable   <= 1'b0;
      end else begin
         state        <= state_nxt;
         cur_state    <= cur_state_nxt;
         data_out     <= data_out_nxt;
         round_num    <= round_nxt;
         busy         <= (state_nxt != ST_IDLE);
         done         <= (state_nxt == ST_DONE);
         sbox_enable  <= (state_nxt == ST_SUB);
         srows_enable <= (state_nxt == ST_SHIFT);
         mcols_enable <= (state_nxt == ST_MIX);
         ark_enable   <= (state_nxt == ST_INIT_ARK) || (state_nxt == ST_ARK);
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl using behavioural AES step units and the
// FIPS-197 App. B vector.
module tb_aes_round_ctrl;

   localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk = 1'b0;
   logic         rst, start, abort;
   logic [127:0] data_in;
   logic         busy, done;
   logic [127:0] data_out, cur_state;
   logic [3:0]   round_num;
   logic         sbox_enable, srows_enable, mcols_enable, ark_enable;
   logic [127:0] sbox_out, srows_out, mcols_out, ark_out;
   logic         sbox_done;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [7:0]   sbox_tab [256];
   logic [127:0] rk [16];
   int unsigned  sbox_lat = 0;
   logic [3:0]   sub_cnt = '0;
   bit           trace_on = 0;
   logic [7:0]   trace [$];

   always #5 clk = ~clk;

   aes_round_ctrl #(.NUM_ROUNDS(10), .RW(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .data_in(data_in),
      .busy(busy), .done(done), .data_out(data_out), .cur_state(cur_state),
      .round_num(round_num), .sbox_enable(sbox_enable), .srows_enable(srows_enable),
      .mcols_enable(mcols_enable), .ark_enable(ark_enable), .sbox_out(sbox_out),
      .srows_out(srows_out), .mcols_out(mcols_out), .ark_out(ark_out),
      .sbox_done(sbox_done)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] s, input int i);
      return s[8*(15-i) +: 8];
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*(15-i) +: 8] = sbox_tab[gb(s, i)];
      return r;
   endfunction

   // Byte i of the block sits in row i%4, column i/4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[8*(15-(w+4*c)) +: 8] = gb(s, w + 4*((c+w)%4));
      return r;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
         r[8*(15-4*c) +: 8]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
         r[8*(15-4*c-1) +: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
         r[8*(15-4*c-2) +: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
         r[8*(15-4*c-3) +: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
      end
      return r;
   endfunction

   assign sbox_out  = sub_bytes(cur_state);
   assign srows_out = shift_rows(cur_state);
   assign mcols_out = mix_cols(cur_state);
   assign ark_out   = cur_state ^ rk[round_num];
   assign sbox_done = sbox_enable && (32'(sub_cnt) >= sbox_lat);

   always @(posedge clk) sub_cnt <= sbox_enable ? sub_cnt + 4'd1 : 4'd0;

   always @(negedge clk)
      if (trace_on && busy && !done)
         trace.push_back({sbox_enable, srows_enable, mcols_enable, ark_enable, round_num});

   task automatic build_tables();
      logic [7:0]  inv, b;
      logic [31:0] w [44];
      logic [31:0] t;
      logic [127:0] k;
      logic [7:0]  rcon;
      for (int x = 0; x < 256; x++) begin
         inv = '0;
         if (x != 0) begin
            inv = 8'd1;
            for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
         end
         b = inv;
         sbox_tab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                       ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
      k = KEY;
      for (int i = 0; i < 4; i++) w[i] = k[32*(3-i) +: 32];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'd2);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) rk[r] = '0;
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Edge 0 accepts start; returns the number of edges until done is seen.
   task automatic run_block(input int unsigned lat, input bit hold, output int unsigned edges);
      bit seen = 0;
      sbox_lat = lat;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 if (!hold) start = 1'b0;
      edges = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk); edges++;
         @(negedge clk); if (done) seen = 1;
      end
      check("done_seen", 128'(seen), 128'(1));
   endtask

   task automatic wait_mix(input int unsigned r);
      bit hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (mcols_enable && round_num == 4'(r)) hit = 1;
      end
      check("reach_mix", 128'(hit), 128'(1));
   endtask

   initial begin
      int unsigned edges;
      logic [7:0] exp_tr [$];
      rst = 1'b1; start = 1'b0; abort = 1'b0; data_in = PT;
      build_tables();
      check("rk10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      repeat (2) @(negedge clk);
      check("rst_busy", 128'(busy), '0);
      check("rst_done", 128'(done), '0);
      check("rst_en", 128'({sbox_enable, srows_enable, mcols_enable, ark_enable}), '0);
      check("rst_state", cur_state, '0);
      check("rst_dout", data_out, '0);
      check("rst_round", 128'(round_num), '0);
      rst = 1'b0;

      // FIPS vector, single-cycle sbox, enable trace
      trace.delete();
      trace_on = 1;
      run_block(0, 0, edges);
      trace_on = 0;
      check("lat_fast", 128'(edges), 128'(40));
      check("ct_fast", data_out, CT);
      exp_tr.push_back({4'b0001, 4'd0});
      for (int r = 1; r <= 10; r++) begin
         exp_tr.push_back({4'b1000, 4'(r)});
         exp_tr.push_back({4'b0100, 4'(r)});
         if (r < 10) exp_tr.push_back({4'b0010, 4'(r)});
         exp_tr.push_back({4'b0001, 4'(r)});
      end
      check("trace_len", 128'(trace.size()), 128'(exp_tr.size()));
      for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
         if (trace[i] !== exp_tr[i]) check($sformatf("trace_%0d", i), 128'(trace[i]), 128'(exp_tr[i]));
      check("trace_ok", 128'(trace == exp_tr), 128'(1));
      @(negedge clk);
      check("done_pulse", 128'(done), '0);
      check("idle_busy", 128'(busy), '0);
      check("dout_hold", data_out, CT);

      // sbox_done high in the third SUB cycle of every round
      run_block(2, 0, edges);
      check("lat_slow", 128'(edges), 128'(60));
      check("ct_slow", data_out, CT);

      // start held through the block and DONE
      run_block(0, 1, edges);
      check("lat_hold", 128'(edges), 128'(40));
      check("ct_hold", data_out, CT);
      @(negedge clk);
      check("hold_idle", 128'(busy), '0);
      @(negedge clk);
      check("hold_restart", 128'({busy, ark_enable, round_num}), 128'({2'b11, 4'd0}));
      start = 1'b0; abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("abort_init_busy", 128'(busy), '0);

      // abort in round 5 MIX
      pulse_start();
      wait_mix(5);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("abort_busy", 128'(busy), '0);
      check("abort_done", 128'(done), '0);
      check("abort_en", 128'({sbox_enable, srows_enable, mcols_enable, ark_enable}), '0);
      check("abort_round", 128'(round_num), 128'(5));
      check("abort_dout", data_out, CT);
      repeat (3) @(negedge clk);
      check("abort_quiet", 128'({busy, done}), '0);
      run_block(0, 0, edges);
      check("lat_after_abort", 128'(edges), 128'(40));
      check("ct_after_abort", data_out, CT);

      // asynchronous reset in round 7
      pulse_start();
      wait_mix(7);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 128'(busy), '0);
      check("arst_en", 128'({sbox_enable, srows_enable, mcols_enable, ark_enable}), '0);
      check("arst_state", cur_state, '0);
      check("arst_dout", data_out, '0);
      check("arst_round", 128'(round_num), '0);
      @(negedge clk); rst = 1'b0;
      run_block(0, 0, edges);
      check("lat_after_rst", 128'(edges), 128'(40));
      check("ct_after_rst", data_out, CT);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
